regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (legal 8..64).
REQ-002 SHALL have parameter AW, default 5, address width; DEPTH = 2^AW registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports a1, a2  input  AW  read addresses, ports 1 and 2.
REQ-006 SHALL have ports rd1, rd2  output  WIDTH  read data, ports 1 and 2.
REQ-007 SHALL have port a3  input  AW  write address.
REQ-008 SHALL have port wd3  input  WIDTH  write data.
REQ-009 SHALL have port we3  input  1  write enable.
REQ-010 SHALL have port dump_req  input  1  start a sequential dump of all registers.
REQ-011 SHALL have port dump_ready  input  1  consumer accepts the current dump beat.
REQ-012 SHALL have port dump_valid  output  1  a dump beat is presented.
REQ-013 SHALL have port dump_idx  output  AW  register index of the current beat.
REQ-014 SHALL have port dump_data  output  WIDTH  register contents of the current beat.
REQ-015 SHALL have port dump_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-016 SHALL hold register 0 at constant zero; writes to a3=0 are discarded.
REQ-017 SHALL write wd3 into register a3 on the rising clk edge when we3=1, a3!=0 and reset=0.
REQ-018 SHALL drive rd1/rd2 combinationally from the array, with zero-latency reads.
REQ-019 SHALL bypass writes: if we3=1, a3!=0 and a3==a1 (or a2), rd1 (or rd2) SHALL equal wd3 in the same cycle.
REQ-020 SHALL return 0 on rdN whenever aN=0, including when a3=0 with we3=1.
REQ-021 SHALL allow both read ports to address the same register; both return identical data.
REQ-022 SHALL implement dump FSM states IDLE and DUMP.
REQ-023 IDLE: dump_valid=0; dump_req=1 at a rising edge -> DUMP, with index counter set to 0.
REQ-024 DUMP: dump_valid=1, dump_idx=counter, dump_data=stored value of register[counter] (no write bypass).
REQ-025 DUMP: the beat is accepted on a rising edge with dump_ready=1; a non-final accepted beat increments the counter.
REQ-026 DUMP: a beat not accepted (dump_ready=0) SHALL hold dump_idx; dump_data tracks any write to that register from the following cycle.
REQ-027 DUMP: acceptance with counter==DEPTH-1 -> IDLE and dump_done=1 for exactly the next cycle; the counter does not wrap.
REQ-028 SHALL ignore dump_req while in DUMP, and while dump_done is high.
REQ-029 SHALL keep register writes and reads fully operational during DUMP; the dump never stalls the write port.
REQ-030 Beat index 0 SHALL always report dump_data=0.

Reset
REQ-031 reset=1 at a rising edge SHALL clear all DEPTH registers to 0, FSM to IDLE, counter to 0.
REQ-032 After reset, outputs SHALL be: dump_valid=0, dump_idx=0, dump_data=0, dump_done=0; rd1/rd2 = 0 for every address.
REQ-033 reset SHALL override a simultaneous we3 write and dump_req; reset mid-dump aborts the dump without asserting dump_done.

Verification
REQ-034 Reset, then write a3=5, wd3=0x1234 -> next cycle a1=5 gives rd1=0x1234; a2=6 gives rd2=0.
REQ-035 Same cycle: we3=1, a3=7, wd3=0xDEAD, a1=a2=7 -> rd1=rd2=0xDEAD before the clock edge (bypass).
REQ-036 we3=1, a3=0, wd3=0xFFFF_FFFF; then a1=0 -> rd1=0 in both the write cycle and later cycles.
REQ-037 Load reg[i]=i*3, pulse dump_req, hold dump_ready=1 -> 32 beats idx 0..31, data 0,3,...,93, then one dump_done pulse, then dump_valid=0.
REQ-038 During a dump, drop dump_ready at idx=4 for 3 cycles and write reg4=0x55 -> idx holds at 4, dump_data becomes 0x55, and the dump resumes at 5 when dump_ready returns.
REQ-039 Assert reset at idx=10 of a dump -> next cycle IDLE, dump_valid=0, dump_done=0, all registers 0; a new dump_req then restarts the dump at idx 0.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised 2-read/1-write register file with register 0 tied to zero,
// write-to-read bypass, and a ready/valid sequential dump of all registers.
module regfile_param #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    a1,
    input  logic [AW-1:0]    a2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic [AW-1:0]    a3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we3,
    input  logic             dump_req,
    input  logic             dump_ready,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_done
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    state_t           state;
    logic [AW-1:0]    counter;
    logic [WIDTH-1:0] regs [DEPTH];
    logic             write_en;

    assign write_en = we3 && (a3 != '0);

    // Register 0 is only ever cleared, so it stays zero forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[a3] <= wd3;
        end
    end

    always_comb begin
        rd1 = regs[a1];
        rd2 = regs[a2];
        if (write_en && (a3 == a1)) rd1 = wd3;
        if (write_en && (a3 == a2)) rd2 = wd3;
        if (a1 == '0) rd1 = '0;
        if (a2 == '0) rd2 = '0;
    end

    // The done pulse also blocks a new request in the cycle right after a dump.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req && !dump_done) begin
                        state   <= DUMP;
                        counter <= '0;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (&counter) begin
                            state     <= IDLE;
                            dump_done <= 1'b1;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dump_valid = (state == DUMP);
    assign dump_idx   = counter;
    assign dump_data  = dump_valid ? regs[counter] : '0;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus a randomized
// phase, all compared against an array-based reference model.
module tb_regfile_param;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    a1, a2, a3;
    logic [WIDTH-1:0] rd1, rd2, wd3;
    logic             we3, dump_req, dump_ready;
    logic             dump_valid, dump_done;
    logic [AW-1:0]    dump_idx;
    logic [WIDTH-1:0] dump_data;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_regs [DEPTH];
    bit               m_dumping;
    int               m_idx;
    bit               m_done;

    regfile_param #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .a3(a3), .wd3(wd3), .we3(we3),
        .dump_req(dump_req), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [AW-1:0] wa,
                                 input logic [WIDTH-1:0] wd, input logic [AW-1:0] ra1,
                                 input logic [AW-1:0] ra2, input logic req, input logic rdy);
        reset = r; we3 = w; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2;
        dump_req = req; dump_ready = rdy;
    endtask

    // Advance one clock and update the reference model with what was presented.
    task automatic step();
        bit final_beat;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
            m_dumping = 0; m_idx = 0; m_done = 0;
        end else begin
            final_beat = m_dumping && dump_ready && (m_idx == DEPTH - 1);
            if (m_dumping) begin
                if (dump_ready) begin
                    if (m_idx == DEPTH - 1) m_dumping = 0;
                    else m_idx = m_idx + 1;
                end
            end else if (dump_req && !m_done) begin
                m_dumping = 1; m_idx = 0;
            end
            m_done = final_beat;
            if (we3 && a3 != 0) m_regs[a3] = wd3;
        end
        #1;
    endtask

    function automatic logic [WIDTH-1:0] modelRead(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we3 && a3 != 0 && a3 == a) return wd3;
        return m_regs[a];
    endfunction

    task automatic checkAll(input string tag);
        #1;
        checkOutput({tag, ".rd1"}, 64'(rd1), 64'(modelRead(a1)));
        checkOutput({tag, ".rd2"}, 64'(rd2), 64'(modelRead(a2)));
        checkOutput({tag, ".valid"}, 64'(dump_valid), 64'(m_dumping));
        checkOutput({tag, ".done"}, 64'(dump_done), 64'(m_done));
        if (m_dumping) begin
            checkOutput({tag, ".idx"}, 64'(dump_idx), 64'(m_idx));
            checkOutput({tag, ".data"}, 64'(dump_data), 64'(m_regs[m_idx]));
        end else begin
            checkOutput({tag, ".data_idle"}, 64'(dump_data), 64'd0);
        end
    endtask

    initial begin
        int guard;
        applyStimulus(1, 1, 5'd3, 32'hABCD, 0, 0, 1, 0);
        step(); step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rst.valid", 64'(dump_valid), 64'd0);
        checkOutput("rst.idx", 64'(dump_idx), 64'd0);
        checkOutput("rst.data", 64'(dump_data), 64'd0);
        checkOutput("rst.done", 64'(dump_done), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            a1 = AW'(i); a2 = AW'(DEPTH - 1 - i); #1;
            checkOutput("rst.rd1", 64'(rd1), 64'd0);
            checkOutput("rst.rd2", 64'(rd2), 64'd0);
        end

        // Basic write then read back.
        applyStimulus(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 5'd5, 5'd6, 0, 0);
        #1;
        checkOutput("wr.rd1", 64'(rd1), 64'h1234);
        checkOutput("wr.rd2", 64'(rd2), 64'd0);

        // Same-cycle bypass on both ports.
        applyStimulus(0, 1, 5'd7, 32'hDEAD, 5'd7, 5'd7, 0, 0);
        #1;
        checkOutput("byp.rd1", 64'(rd1), 64'hDEAD);
        checkOutput("byp.rd2", 64'(rd2), 64'hDEAD);
        step();

        // Writes to register 0 are discarded, including the bypass path.
        applyStimulus(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 0, 0);
        #1;
        checkOutput("r0.bypass", 64'(rd1), 64'd0);
        step();
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd7, 0, 0);
        #1;
        checkOutput("r0.later", 64'(rd1), 64'd0);
        checkOutput("r7.kept", 64'(rd2), 64'hDEAD);

        // Full dump with reg[i] = i*3 and ready always high.
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(0, 1, AW'(i), WIDTH'(i * 3), 0, 0, 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        step();
        dump_req = 0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checkOutput("dump.valid", 64'(dump_valid), 64'd1);
            checkOutput("dump.idx", 64'(dump_idx), 64'(i));
            checkOutput("dump.data", 64'(dump_data), 64'(i * 3));
            step();
        end
        checkOutput("dump.done", 64'(dump_done), 64'd1);
        checkOutput("dump.end_valid", 64'(dump_valid), 64'd0);
        dump_req = 1;
        step();
        dump_req = 0;
        checkOutput("dump.done_pulse", 64'(dump_done), 64'd0);
        checkOutput("dump.req_ignored", 64'(dump_valid), 64'd0);

        // Back-pressure at idx 4 with a write to the held register.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        step();
        dump_req = 0;
        guard = 0;
        while (dump_idx != 4 && guard < 40) begin step(); guard++; end
        checkOutput("bp.reach4", 64'(guard < 40), 64'd1);
        applyStimulus(0, 1, 5'd4, 32'h55, 0, 0, 0, 0);
        checkAll("bp.c0");
        step();
        we3 = 0;
        for (int k = 0; k < 2; k++) begin
            checkAll("bp.hold");
            checkOutput("bp.idx", 64'(dump_idx), 64'd4);
            checkOutput("bp.data", 64'(dump_data), 64'h55);
            step();
        end
        dump_ready = 1;
        step();
        checkOutput("bp.resume", 64'(dump_idx), 64'd5);
        checkAll("bp.after");

        // Reset in the middle of a dump aborts it silently.
        guard = 0;
        while (dump_idx != 10 && guard < 40) begin step(); guard++; end
        checkOutput("mid.reach10", 64'(guard < 40), 64'd1);
        reset = 1;
        step();
        reset = 0; dump_ready = 0;
        #1;
        checkOutput("mid.valid", 64'(dump_valid), 64'd0);
        checkOutput("mid.done", 64'(dump_done), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            a1 = AW'(i); #1;
            checkOutput("mid.regs", 64'(rd1), 64'd0);
        end
        dump_req = 1;
        step();
        dump_req = 0;
        checkOutput("mid.restart_valid", 64'(dump_valid), 64'd1);
        checkOutput("mid.restart_idx", 64'(dump_idx), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
                          AW'($urandom), $urandom, AW'($urandom), AW'($urandom),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 3) == 0) a2 = a1;
            if ($urandom_range(0, 3) == 0) a1 = a3;
            checkAll("rnd");
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
